// File: rtl/uart_tx_if.sv
// Write-side handshake bundle for the UART transmitter byte FIFO.
// A byte moves on a rising edge where wr_valid && wr_ready.
interface uart_tx_if;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;

   modport master (
      output wr_data,
      output wr_valid,
      input  wr_ready
   );

   modport slave (
      input  wr_data,
      input  wr_valid,
      output wr_ready
   );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a small circular byte FIFO on the
// write side. Frames are sent back-to-back with no idle gap while bytes are
// queued. TXD is registered and idles high.
module uart_tx #(
   parameter int CLK_FREQ_HZ = 12000000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                             CLK,
   input  logic                             resetn,
   uart_tx_if.slave                         wr,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
   output logic                             tx_busy,
   output logic                             TXD
);

   // Clocks per serial bit; integer truncation, expected to be >= 2.
   localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
   localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   // Engine states
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [7:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   logic [1:0]        state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shift;

   logic              push;
   logic              pop;
   logic              baud_last;
   logic              fifo_nonempty;

   // Full is judged from the registered count only, so a pop on the same
   // edge never lets a full FIFO take a write.
   assign wr.wr_ready    = (fifo_count != CNT_FULL);
   assign push           = wr.wr_valid && wr.wr_ready;
   assign fifo_nonempty  = (fifo_count != '0);
   assign baud_last      = (baud_cnt == BAUD_LAST);

   // The head leaves the FIFO only from IDLE or on the final STOP cycle.
   assign pop            = fifo_nonempty &&
                           ((state == IDLE) || ((state == STOP) && baud_last));

   assign tx_busy        = (state != IDLE) || fifo_nonempty;

   // FIFO storage: written at the tail on every accepted byte.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= wr.wr_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally modulo FIFO_DEPTH.
   always_ff @(posedge CLK) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Shift register: loaded on pop, shifted right at each data-bit boundary.
   always_ff @(posedge CLK) begin
      if (pop) begin
         shift <= mem[rd_ptr];
      end else if ((state == DATA) && baud_last) begin
         shift <= {1'b0, shift[7:1]};
      end
   end

   // Frame engine; TXD is loaded with the level of the state being entered.
   always_ff @(posedge CLK) begin
      if (!resetn) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         TXD      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               if (pop) begin
                  state <= START;
                  TXD   <= 1'b0;
               end else begin
                  TXD   <= 1'b1;
               end
            end

            START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
                  TXD      <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     TXD   <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     // shift[1] becomes shift[0] on this same edge
                     TXD     <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     // Next frame starts immediately, no idle cycle
                     state <= START;
                     TXD   <= 1'b0;
                  end else begin
                     state <= IDLE;
                     TXD   <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            default: begin
               state    <= IDLE;
               baud_cnt <= '0;
               TXD      <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (BAUD_DIV=4, FIFO_DEPTH=4).
// A line decoder turns TXD back into bytes; expected bytes and waveforms
// are derived from the 8N1 frame definition.
module tb_uart_tx;

   localparam int BAUD_DIV = 4;
   localparam int FRAME    = 10 * BAUD_DIV;

   logic       CLK = 1'b0;
   logic       resetn;
   logic [2:0] fifo_count;
   logic       tx_busy;
   logic       TXD;

   uart_tx_if wr_if ();

   uart_tx #(
      .CLK_FREQ_HZ (400),
      .BAUD_RATE   (100),
      .FIFO_DEPTH  (4)
   ) dut (
      .CLK        (CLK),
      .resetn     (resetn),
      .wr         (wr_if),
      .fifo_count (fifo_count),
      .tx_busy    (tx_busy),
      .TXD        (TXD)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Line level of slot j (0=start, 1..8=data LSB first, 9=stop) of a frame
   function automatic logic level(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return b[j-1];
   endfunction

   // ---------------- line decoder ----------------
   bit         mon_en = 1'b0;
   bit         m_act  = 1'b0;
   int         m_t    = 0;
   logic [7:0] m_byte;
   logic [7:0] rx_q [$];
   int         start_q [$];
   int         frame_err = 0;

   always @(negedge CLK) begin
      if (!mon_en) begin
         m_act = 1'b0;
      end else if (!m_act) begin
         if (TXD === 1'b0) begin
            m_act = 1'b1;
            m_t   = 0;
            start_q.push_back(cyc);
         end
      end else begin
         m_t++;
         if (m_t == 2) begin
            if (TXD !== 1'b0) frame_err++;
         end else if (m_t >= 6 && m_t <= 34 && ((m_t - 6) % 4) == 0) begin
            m_byte[(m_t - 6) / 4] = TXD;
         end else if (m_t == 38) begin
            if (TXD === 1'b1) rx_q.push_back(m_byte);
            else frame_err++;
            m_act = 1'b0;
         end
      end
   end

   task automatic wait_idle(input string tag, input int budget);
      int k = 0;
      while (tx_busy !== 1'b0 && k < budget) begin
         @(negedge CLK);
         k++;
      end
      chk(tag, tx_busy, 0);
   endtask

   task automatic wait_rx(input string tag, input int n, input int budget);
      int k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(negedge CLK);
         k++;
      end
      chk(tag, rx_q.size(), n);
   endtask

   logic [7:0] exp_q [$];
   logic [7:0] t4 [6];
   int exp_cnt4 [6] = '{1, 1, 2, 3, 4, 4};
   int exp_rdy4 [6] = '{1, 1, 1, 1, 0, 0};
   int a3_bits  [8] = '{1, 1, 0, 0, 0, 1, 0, 1};

   initial begin
      int m;
      int idx;
      int k;
      bit low;

      resetn          = 1'b0;
      wr_if.wr_valid  = 1'b0;
      wr_if.wr_data   = 8'h00;
      @(negedge CLK);
      @(negedge CLK);
      chk("rst_txd", TXD, 1);
      chk("rst_ready", wr_if.wr_ready, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_count", fifo_count, 0);
      resetn = 1'b1;
      mon_en = 1'b1;

      // 1: idle after reset
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         chk("idle_txd", TXD, 1);
         chk("idle_ready", wr_if.wr_ready, 1);
         chk("idle_busy", tx_busy, 0);
         chk("idle_count", fifo_count, 0);
      end

      // 2: single frame 0x55, cycle-exact waveform
      rx_q.delete();
      wr_if.wr_data  = 8'h55;
      wr_if.wr_valid = 1'b1;
      @(negedge CLK);
      wr_if.wr_valid = 1'b0;
      chk("t2_count_after_write", fifo_count, 1);
      chk("t2_txd_after_write", TXD, 1);
      chk("t2_busy_after_write", tx_busy, 1);
      for (int i = 1; i <= FRAME; i++) begin
         @(negedge CLK);
         chk("t2_txd", TXD, level(8'h55, (i - 1) / BAUD_DIV));
         chk("t2_busy", tx_busy, 1);
      end
      @(negedge CLK);
      chk("t2_busy_end", tx_busy, 0);
      chk("t2_txd_end", TXD, 1);
      chk("t2_rx_n", rx_q.size(), 1);
      chk("t2_rx", rx_q[0], 8'h55);

      // 3: two back-to-back frames
      rx_q.delete();
      start_q.delete();
      wr_if.wr_data  = 8'h01;
      wr_if.wr_valid = 1'b1;
      @(negedge CLK);
      m = cyc;
      wr_if.wr_data  = 8'hA3;
      @(negedge CLK);
      wr_if.wr_valid = 1'b0;
      wait_rx("t3_rx_n", 2, 3 * FRAME);
      wait_idle("t3_idle", 2 * FRAME);
      chk("t3_rx0", rx_q[0], 8'h01);
      chk("t3_rx1", rx_q[1], 8'hA3);
      for (int b = 0; b < 8; b++) chk("t3_a3_bit", rx_q[1][b], a3_bits[b]);
      chk("t3_first_start", start_q[0], m + 1);
      chk("t3_gap", start_q[1] - start_q[0], FRAME);

      // 4: overfill with six random bytes, last one dropped
      rx_q.delete();
      for (int i = 0; i < 6; i++) t4[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
         wr_if.wr_data  = t4[i];
         wr_if.wr_valid = 1'b1;
         @(negedge CLK);
         chk("t4_count", fifo_count, exp_cnt4[i]);
         chk("t4_ready", wr_if.wr_ready, exp_rdy4[i]);
      end
      wr_if.wr_valid = 1'b0;
      wait_rx("t4_rx_n", 5, 6 * FRAME);
      wait_idle("t4_idle", 2 * FRAME);
      chk("t4_rx_total", rx_q.size(), 5);
      for (int i = 0; i < 5; i++) chk("t4_rx", rx_q[i], t4[i]);

      // 5: stream 0x00..0x09 whenever ready
      rx_q.delete();
      exp_q.delete();
      idx = 0;
      k = 0;
      while (idx < 10 && k < 2000) begin
         if (wr_if.wr_ready === 1'b1) begin
            wr_if.wr_data  = 8'(idx);
            wr_if.wr_valid = 1'b1;
            exp_q.push_back(8'(idx));
            idx++;
         end else begin
            wr_if.wr_valid = 1'b0;
         end
         @(negedge CLK);
         k++;
      end
      wr_if.wr_valid = 1'b0;
      wait_rx("t5_rx_n", 10, 12 * FRAME);
      wait_idle("t5_idle", 2 * FRAME);
      chk("t5_rx_total", rx_q.size(), 10);
      for (int i = 0; i < 10; i++) chk("t5_rx", rx_q[i], exp_q[i]);

      // random bytes with random write gaps
      rx_q.delete();
      exp_q.delete();
      idx = 0;
      k = 0;
      while (idx < 12 && k < 3000) begin
         if (wr_if.wr_ready === 1'b1 && $urandom_range(0, 2) != 0) begin
            wr_if.wr_data  = 8'($urandom);
            wr_if.wr_valid = 1'b1;
            exp_q.push_back(wr_if.wr_data);
            idx++;
         end else begin
            wr_if.wr_valid = 1'b0;
         end
         @(negedge CLK);
         k++;
      end
      wr_if.wr_valid = 1'b0;
      wait_rx("rnd_rx_n", 12, 14 * FRAME);
      wait_idle("rnd_idle", 2 * FRAME);
      chk("rnd_rx_total", rx_q.size(), 12);
      for (int i = 0; i < 12; i++) chk("rnd_rx", rx_q[i], exp_q[i]);

      // 6: reset during data bit 3 of 0xFF with two bytes queued
      rx_q.delete();
      wr_if.wr_data  = 8'hFF;
      wr_if.wr_valid = 1'b1;
      @(negedge CLK);                       // after edge N
      wr_if.wr_data  = 8'($urandom);
      @(negedge CLK);                       // N+1
      wr_if.wr_data  = 8'($urandom);
      @(negedge CLK);                       // N+2
      wr_if.wr_valid = 1'b0;
      repeat (16) @(negedge CLK);           // N+18, inside data bit 3
      chk("t6_count_before", fifo_count, 2);
      chk("t6_txd_before", TXD, 1);
      chk("t6_busy_before", tx_busy, 1);
      mon_en = 1'b0;
      resetn = 1'b0;
      @(negedge CLK);
      resetn = 1'b1;
      chk("t6_txd", TXD, 1);
      chk("t6_count", fifo_count, 0);
      chk("t6_busy", tx_busy, 0);
      chk("t6_ready", wr_if.wr_ready, 1);
      rx_q.delete();
      mon_en = 1'b1;
      low = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (TXD !== 1'b1 || tx_busy !== 1'b0) low = 1'b1;
      end
      chk("t6_quiet", low, 0);
      chk("t6_rx_none", rx_q.size(), 0);

      chk("frame_errors", frame_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
